// File: rtl/ldpc_cnu_pkg.sv
// Shared types and constants for the layered-LDPC check-node sequencer.
package ldpc_cnu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam int DEF_RD_LATENCY = 2;
  localparam int DEF_MS_LATENCY = 5;
  localparam int CNU_INPUTS     = 6;

endpackage

// File: rtl/ldpc_delay_line.sv
// Fixed-latency {valid, data} shift register used to align CNU strobes and write-back rows.
module ldpc_delay_line #(
  parameter int DEPTH      = 1,
  parameter int WIDTH      = 8,
  parameter bit COUNT_LAST = 1'b1
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_any_valid
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  // NOTE: state registers update with <= so every stage samples its predecessor's old value.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= i_valid;
      for (int i = 1; i < DEPTH; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  // NOTE: payload stages are not reset; the valid bits alone qualify them and o_data is masked.
  always_ff @(posedge i_clock) begin
    data_q[0] <= i_data;
    for (int i = 1; i < DEPTH; i++) data_q[i] <= data_q[i-1];
  end

  assign o_valid = valid_q[DEPTH-1];
  assign o_data  = o_valid ? data_q[DEPTH-1] : '0;

  // Without the output stage, the flag means "still in flight after the next edge".
  generate
    if (COUNT_LAST) begin : g_all
      assign o_any_valid = |valid_q;
    end else if (DEPTH > 1) begin : g_pending
      assign o_any_valid = |valid_q[DEPTH-2:0];
    end else begin : g_none
      assign o_any_valid = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/ldpc_cnu_sequencer.sv
// Row/iteration sequencer for the min-sign CNU with pipeline-aligned write-back.
// Optional early termination on syndrome check: define LDPC_CNU_SEQ_EARLY_TERM_EN.
module ldpc_cnu_sequencer
  import ldpc_cnu_pkg::*;
#(
  parameter int ROW_W      = 8,
  parameter int ITER_W     = 5,
  parameter int RD_LATENCY = DEF_RD_LATENCY,
  parameter int MS_LATENCY = DEF_MS_LATENCY
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [ROW_W-1:0]  i_num_rows,
  input  logic [ITER_W-1:0] i_num_iters,
  input  logic              i_abort,
`ifdef LDPC_CNU_SEQ_EARLY_TERM_EN
  input  logic              i_syndrome_ok,
  output logic              o_early_term,
`endif
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [ROW_W-1:0]  o_rd_addr,
  output logic              o_ms_latch,
  output logic              o_wr_en,
  output logic [ROW_W-1:0]  o_wr_addr,
  output logic [ITER_W-1:0] o_iter
);

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d, rows_q, rows_d;
  logic [ITER_W-1:0] iter_q, iter_d, iters_q, iters_d;
  logic              abort_q, abort_d;
  logic [ITER_W:0]   iter_inc;
  logic [ROW_W-1:0]  ms_addr;
  logic              ms_any, wr_any, drain_done;
`ifdef LDPC_CNU_SEQ_EARLY_TERM_EN
  logic              early_q, early_d;
`endif

  assign o_rd_en    = (state_q == S_ISSUE) && !i_abort;
  assign o_rd_addr  = o_rd_en ? row_q : '0;
  assign o_busy     = (state_q != S_IDLE);
  assign o_done     = (state_q == S_DONE);
  assign o_iter     = iter_q;
  assign iter_inc   = {1'b0, iter_q} + (ITER_W+1)'(1);
  assign drain_done = !ms_any && !wr_any;

  ldpc_delay_line #(.DEPTH(RD_LATENCY), .WIDTH(ROW_W), .COUNT_LAST(1'b1)) u_rd_line (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_valid    (o_rd_en),
    .i_data     (o_rd_addr),
    .o_valid    (o_ms_latch),
    .o_data     (ms_addr),
    .o_any_valid(ms_any)
  );

  ldpc_delay_line #(.DEPTH(MS_LATENCY), .WIDTH(ROW_W), .COUNT_LAST(1'b0)) u_ms_line (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_valid    (o_ms_latch),
    .i_data     (ms_addr),
    .o_valid    (o_wr_en),
    .o_data     (o_wr_addr),
    .o_any_valid(wr_any)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      rows_q  <= '0;
      iter_q  <= '0;
      iters_q <= '0;
      abort_q <= 1'b0;
`ifdef LDPC_CNU_SEQ_EARLY_TERM_EN
      early_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      rows_q  <= rows_d;
      iter_q  <= iter_d;
      iters_q <= iters_d;
      abort_q <= abort_d;
`ifdef LDPC_CNU_SEQ_EARLY_TERM_EN
      early_q <= early_d;
`endif
    end
  end

`ifdef LDPC_CNU_SEQ_EARLY_TERM_EN
  assign o_early_term = early_q;
`endif

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no branch can infer a latch.
    state_d = state_q;
    row_d   = row_q;
    rows_d  = rows_q;
    iter_d  = iter_q;
    iters_d = iters_q;
    abort_d = abort_q;
`ifdef LDPC_CNU_SEQ_EARLY_TERM_EN
    early_d = early_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          rows_d  = i_num_rows;
          iters_d = i_num_iters;
          iter_d  = '0;
          row_d   = '0;
          abort_d = 1'b0;
`ifdef LDPC_CNU_SEQ_EARLY_TERM_EN
          early_d = 1'b0;
`endif
          state_d = (i_num_rows == '0 || i_num_iters == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_abort) begin
          abort_d = 1'b1;
          state_d = S_DRAIN;
        end else begin
          row_d = row_q + ROW_W'(1);
          if (row_q == rows_q - ROW_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (i_abort) abort_d = 1'b1;
        // Leave once the write-back in this cycle is the last one in flight.
        if (drain_done) begin
          if (abort_q || i_abort) begin
            state_d = S_DONE;
`ifdef LDPC_CNU_SEQ_EARLY_TERM_EN
          end else if (i_syndrome_ok) begin
            early_d = 1'b1;
            state_d = S_DONE;
`endif
          end else if (iter_inc < {1'b0, iters_q}) begin
            iter_d  = iter_inc[ITER_W-1:0];
            row_d   = '0;
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule
